// File: rtl/uart_rx_frame_parser_if.sv
// Byte-wide AXI-Stream link used on both sides of uart_rx_frame_parser.
// A beat transfers on a rising edge where tvalid && tready; the sender holds tdata/tlast stable until then.
interface uart_rx_frame_parser_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from a UART byte stream and releases only checksum-verified payloads.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_parser #(
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 32,
  parameter int         TIMEOUT_CLKS = 16*10*4
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  uart_rx_frame_parser_if.slave  s_axis,
  uart_rx_frame_parser_if.master m_axis,
  output logic                   o_err_len,
  output logic                   o_err_chk,
  output logic                   o_err_timeout,
  output logic [15:0]            o_frame_cnt,
  output logic [2:0]             dbg_state
);
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         DEPTH     = 1 << AW;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, EMIT} state_t;

  state_t        state_q, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] last_q, last_n, idx_q, idx_n, idx_inc;
  logic [7:0]    sum_q, sum_n;
  logic [7:0]    data_q, data_n;
  logic          ready_q, ready_n, valid_q, valid_n, tlast_q, tlast_n;
  logic          err_len_q, err_len_n, err_chk_q, err_chk_n;
  logic [15:0]   cnt_q, cnt_n;
  logic          acc, wr_en, len_ok;

  assign acc     = s_axis.tvalid && ready_q;
  assign idx_inc = idx_q + 1'b1;
  assign len_ok  = (s_axis.tdata != 8'd0) && (s_axis.tdata <= MAX_LEN_B);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_q, to_n;
  logic          err_to_q, err_to_n;
`endif

  always_comb begin
    state_n   = state_q;
    last_n    = last_q;
    idx_n     = idx_q;
    sum_n     = sum_q;
    data_n    = data_q;
    valid_n   = valid_q;
    tlast_n   = tlast_q;
    err_len_n = 1'b0;
    err_chk_n = 1'b0;
    cnt_n     = cnt_q;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: if (acc && s_axis.tdata == SOF_BYTE) state_n = LEN;
      LEN: if (acc) begin
        if (len_ok) begin
          // Store len-1 so the index compare stays within the buffer address width.
          last_n  = AW'(s_axis.tdata - 8'd1);
          sum_n   = 8'd0;
          idx_n   = '0;
          state_n = PAYLOAD;
        end else begin
          err_len_n = 1'b1;
          state_n   = IDLE;
        end
      end
      PAYLOAD: if (acc) begin
        // Checksum is the mod-256 sum of the payload bytes only.
        wr_en = 1'b1;
        sum_n = sum_q + s_axis.tdata;
        idx_n = idx_inc;
        if (idx_q == last_q) state_n = CHK;
      end
      CHK: if (acc) begin
        if (s_axis.tdata == sum_q) begin
          state_n = EMIT;
          idx_n   = '0;
          valid_n = 1'b1;
          data_n  = mem[AW'(0)];
          tlast_n = (last_q == '0);
        end else begin
          err_chk_n = 1'b1;
          state_n   = IDLE;
        end
      end
      EMIT: if (m_axis.tready) begin
        if (tlast_q) begin
          valid_n = 1'b0;
          tlast_n = 1'b0;
          cnt_n   = cnt_q + 16'd1;
          state_n = IDLE;
        end else begin
          idx_n   = idx_inc;
          data_n  = mem[idx_inc];
          tlast_n = (idx_inc == last_q);
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef UART_FRAME_TIMEOUT_EN
    to_n     = '0;
    err_to_n = 1'b0;
    // An accepted byte always wins over an expiring timer in the same cycle.
    if ((state_q == LEN || state_q == PAYLOAD || state_q == CHK) && !acc) begin
      if (to_q == TW'(TIMEOUT_CLKS - 1)) begin
        err_to_n = 1'b1;
        state_n  = IDLE;
      end else begin
        to_n = to_q + 1'b1;
      end
    end
`endif
    ready_n = (state_n != EMIT);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      last_q    <= '0;
      idx_q     <= '0;
      sum_q     <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      tlast_q   <= 1'b0;
      ready_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_n;
      last_q    <= last_n;
      idx_q     <= idx_n;
      sum_q     <= sum_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      tlast_q   <= tlast_n;
      ready_q   <= ready_n;
      err_len_q <= err_len_n;
      err_chk_q <= err_chk_n;
      cnt_q     <= cnt_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[idx_q] <= s_axis.tdata;
  end

`ifdef UART_FRAME_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      to_q     <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_q     <= to_n;
      err_to_q <= err_to_n;
    end
  end
  assign o_err_timeout = err_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CLKS;
  assign o_err_timeout  = 1'b0;
`endif

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = data_q;
  assign m_axis.tlast  = tlast_q;
  assign o_err_len     = err_len_q;
  assign o_err_chk     = err_chk_q;
  assign o_frame_cnt   = cnt_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: expected payload beats queue up as frames are driven
// and are popped by an output monitor; error pulses and the frame counter are checked per step.
module tb_uart_rx_frame_parser;
  localparam int MAX_LEN      = 32;
  localparam int TIMEOUT_CLKS = 100;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_len, err_chk, err_to;
  logic [15:0] frame_cnt;
  logic [2:0]  dbg_state;

  uart_rx_frame_parser_if s_if();
  uart_rx_frame_parser_if m_if();

  uart_rx_frame_parser #(
    .SOF_BYTE    (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .i_clk        (clk),
    .i_arst_n     (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .o_err_len    (err_len),
    .o_err_chk    (err_chk),
    .o_err_timeout(err_to),
    .o_frame_cnt  (frame_cnt),
    .dbg_state    (dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  int          n_len = 0, n_chk = 0, n_to = 0;
  bit          bp_mode = 1'b0;
  logic        rdy_default = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: start and end on a falling edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = b;
    while (!s_if.tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_in_time", 32'(n < 200), 1);
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_good(input int len);
    logic [7:0] pl [256];
    logic [7:0] sum = 8'd0;
    for (int i = 0; i < len; i++) begin
      pl[i] = 8'($urandom_range(0, 255));
      sum  += pl[i];
      exp_q.push_back({i == len - 1, pl[i]});
    end
    send_byte(8'hA5);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(pl[i]);
    send_byte(sum);
    chk("first_valid_latency", m_if.tvalid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 300), 1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_s_tready"}, s_if.tready, 0);
    chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_m_tdata"}, m_if.tdata, 0);
    chk({tag, "_m_tlast"}, m_if.tlast, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    exp_q.delete();
    exp_cnt = 16'd0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_after_release"}, s_if.tready, 1);
  endtask

  // downstream ready driver
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(negedge clk);
      if (bp_mode) m_if.tready = 1'($urandom_range(0, 1));
      else         m_if.tready = rdy_default;
    end
  end

  // scoreboard / output monitor
  logic       stall_q = 1'b0, more_q = 1'b0, prev_len = 1'b0, prev_chk = 1'b0, prev_to = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      stall_q  = 1'b0;
      more_q   = 1'b0;
      prev_len = 1'b0;
      prev_chk = 1'b0;
      prev_to  = 1'b0;
    end else begin
      if (more_q) chk("back_to_back_valid", m_if.tvalid, 1);
      if (m_if.tvalid) begin
        chk("s_tready_low_in_emit", s_if.tready, 0);
        if (stall_q) begin
          chk("hold_tdata", m_if.tdata, hold_data);
          chk("hold_tlast", m_if.tlast, hold_last);
        end
        if (m_if.tready) begin
          chk("beat_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("beat_value", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
        end
      end
      stall_q   = m_if.tvalid && !m_if.tready;
      more_q    = m_if.tvalid && m_if.tready && !m_if.tlast;
      hold_data = m_if.tdata;
      hold_last = m_if.tlast;
      if (err_len) begin n_len++; chk("err_len_width", prev_len, 0); end
      if (err_chk) begin n_chk++; chk("err_chk_width", prev_chk, 0); end
      if (err_to)  begin n_to++;  chk("err_to_width", prev_to, 0); end
      if (err_len || err_chk || err_to) chk("err_onehot", $countones({err_len, err_chk, err_to}), 1);
      prev_len = err_len;
      prev_chk = err_chk;
      prev_to  = err_to;
    end
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    idle(3);
    chk("reset_s_tready", s_if.tready, 0);
    chk("reset_m_tvalid", m_if.tvalid, 0);
    chk("reset_m_tdata", m_if.tdata, 0);
    chk("reset_m_tlast", m_if.tlast, 0);
    chk("reset_errs", {err_len, err_chk, err_to}, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", s_if.tready, 1);

    // good frame, downstream always ready
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);
    chk("t1_first_valid_latency", m_if.tvalid, 1);
    chk("t1_first_tdata", m_if.tdata, 8'h11);
    drain();
    exp_cnt++;
    chk("t1_frame_cnt", frame_cnt, exp_cnt);
    chk("t1_no_err", n_len + n_chk + n_to, 0);

    // leading junk, SOF value inside the frame, random backpressure
    bp_mode = 1'b1;
    exp_q.push_back(9'h0A5); exp_q.push_back(9'h101);
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA6);
    chk("t2_first_valid_latency", m_if.tvalid, 1);
    drain();
    bp_mode = 1'b0;
    exp_cnt++;
    chk("t2_frame_cnt", frame_cnt, exp_cnt);

    // length errors; a rejected LEN byte equal to SOF must not start a frame
    send_byte(8'hA5); send_byte(8'h00);
    idle(2);
    chk("t3_len_zero", n_len, 1);
    send_byte(8'hA5); send_byte(8'h21);
    idle(2);
    chk("t3_len_over", n_len, 2);
    send_byte(8'hA5); send_byte(8'hA5);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);
    idle(4);
    chk("t3_len_sof_value", n_len, 3);
    chk("t3_no_output", m_if.tvalid, 0);
    send_good(1);
    drain();
    exp_cnt++;
    chk("t3_frame_cnt_len1", frame_cnt, exp_cnt);
    send_good(MAX_LEN);
    drain();
    exp_cnt++;
    chk("t3_frame_cnt_max", frame_cnt, exp_cnt);

    // checksum error
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    idle(4);
    chk("t4_chk_err", n_chk, 1);
    chk("t4_no_output", m_if.tvalid, 0);
    chk("t4_frame_cnt", frame_cnt, exp_cnt);
    chk("t4_len_err_unchanged", n_len, 3);

    // reset after payload byte 2 of a 4-byte frame
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    do_reset("t5_midframe");
    send_good(4);
    drain();
    exp_cnt++;
    chk("t5_frame_cnt", frame_cnt, 16'd1);

    // reset during EMIT with downstream stalled
    rdy_default = 1'b0;
    send_good(3);
    idle(4);
    chk("t6_emit_hold_valid", m_if.tvalid, 1);
    chk("t6_emit_hold_data", m_if.tdata, exp_q[0][7:0]);
    do_reset("t6_emit");
    rdy_default = 1'b1;
    send_good(5);
    drain();
    exp_cnt++;
    chk("t6_frame_cnt", frame_cnt, 16'd1);

    // inter-byte gap
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11);
    idle(TIMEOUT_CLKS + 2);
`ifdef UART_FRAME_TIMEOUT_EN
    chk("t7_timeout_pulse", n_to, 1);
    send_good(2);
    drain();
    exp_cnt++;
    chk("t7_frame_cnt", frame_cnt, exp_cnt);
`else
    chk("t7_no_timeout_pulse", n_to, 0);
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h033); exp_q.push_back(9'h144);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'hAA);
    drain();
    exp_cnt++;
    chk("t7_frame_cnt", frame_cnt, exp_cnt);
`endif
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_chk_errs", n_chk, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
